frog_input_ctrl: RTL and testbench

Keyboard front end between the Nios keycode PIO and the frog/colour-mapper logic. Synchronises the 16-bit keycode into the `Clk` domain and turns it into frame-aligned, one-frame-wide movement strobes with hold-to-repeat. It also latches the active-frog selection, replacing the ad-hoc keycode comparisons in the top level. Outputs feed the frog instances' `up/down/left/right` and `active` inputs directly.

---
 rtl/frog_input_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_frog_input_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frog_input_ctrl.sv
// frog_input_ctrl: keyboard front end for the frog game.
// Synchronises the Nios keycode and VGA vsync into the Clk domain, decodes arrow
// keys into frame-aligned one-frame move strobes with hold-to-repeat, and latches
// the active-frog selection.
//
// Ports
//   Clk, Reset_n          : system clock, asynchronous active-low reset
//   keycode[15:0]         : raw keycode from the Nios PIO (asynchronous)
//   frame_clk             : VGA vsync, treated as data in the Clk domain
//   up/down/left/right    : registered move strobes, one-hot or zero, one frame wide
//   frog_1/2/3_key        : registered one-hot active-frog select (or all zero)
//   last_key[7:0]         : low byte of the last nonzero synchronised keycode
//   move_count[7:0]       : number of moves issued, wraps at 256
module frog_input_ctrl #(
    parameter int unsigned REPEAT_DELAY  = 8,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] keycode,
    input  logic        frame_clk,
    output logic        up,
    output logic        down,
    output logic        left,
    output logic        right,
    output logic        frog_1_key,
    output logic        frog_2_key,
    output logic        frog_3_key,
    output logic [7:0]  last_key,
    output logic [7:0]  move_count
);

    localparam int unsigned KC_W   = 16;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned MV_W   = 4;
    localparam int unsigned FROG_W = 3;
    localparam int unsigned LK_W   = 8;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    localparam logic [KC_W-1:0] KC_LEFT  = 16'h0050;
    localparam logic [KC_W-1:0] KC_RIGHT = 16'h004F;
    localparam logic [KC_W-1:0] KC_UP    = 16'h0052;
    localparam logic [KC_W-1:0] KC_DOWN  = 16'h0051;
    localparam logic [KC_W-1:0] KC_FROG1 = 16'h0059;
    localparam logic [KC_W-1:0] KC_FROG2 = 16'h005A;
    localparam logic [KC_W-1:0] KC_FROG3 = 16'h005B;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_LEFT  = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_UP    = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } state_e;

    // Strobe vector order is {up, down, left, right}.
    function automatic logic [MV_W-1:0] dir_onehot(input dir_e d);
        logic [MV_W-1:0] v;
        v = '0;
        case (d)
            DIR_UP:    v = 4'b1000;
            DIR_DOWN:  v = 4'b0100;
            DIR_LEFT:  v = 4'b0010;
            DIR_RIGHT: v = 4'b0001;
            default:   v = '0;
        endcase
        return v;
    endfunction

    logic [KC_W-1:0]   kc_s1, kc_q;
    logic [2:0]        fs_q;
    logic              frame_tick;
    dir_e              dir, prev_dir, pending_dir, held_dir, held_d, issue;
    logic              pending_valid, consume;
    state_e            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d, cnt_inc;
    logic [MV_W-1:0]   mv_q;
    logic [FROG_W-1:0] frog_q;
    logic [LK_W-1:0]   last_key_q, move_count_q;

    // Two-flop keycode synchroniser and three-flop vsync edge detector.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            kc_s1 <= '0;
            kc_q  <= '0;
            fs_q  <= '0;
        end else begin
            kc_s1 <= keycode;
            kc_q  <= kc_s1;
            fs_q  <= {fs_q[1:0], frame_clk};
        end
    end

    assign frame_tick = fs_q[1] & ~fs_q[2];

    // Exact-match arrow decode; anything else (including multi-key codes) is NONE.
    always_comb begin
        dir = DIR_NONE;
        case (kc_q)
            KC_LEFT:  dir = DIR_LEFT;
            KC_RIGHT: dir = DIR_RIGHT;
            KC_UP:    dir = DIR_UP;
            KC_DOWN:  dir = DIR_DOWN;
            default:  dir = DIR_NONE;
        endcase
    end

    // Press capture: remembers a new direction until a tick consumes it, so a tap
    // shorter than a frame still produces a move. A press on the tick cycle wins.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_dir      <= DIR_NONE;
            pending_valid <= 1'b0;
            pending_dir   <= DIR_NONE;
        end else begin
            prev_dir <= dir;
            if (dir != DIR_NONE && dir != prev_dir) begin
                pending_valid <= 1'b1;
                pending_dir   <= dir;
            end else if (consume) begin
                pending_valid <= 1'b0;
            end
        end
    end

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 6'd1;

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_IDLE;
            held_dir <= DIR_NONE;
            cnt      <= '0;
        end else begin
            state    <= state_d;
            held_dir <= held_d;
            cnt      <= cnt_d;
        end
    end

    // FSM next state. The tick on which the hold delay expires is itself the first
    // repeated move, so repeats land REPEAT_DELAY frames after the first move and
    // then every REPEAT_PERIOD frames.
    always_comb begin
        state_d = state;
        held_d  = held_dir;
        cnt_d   = cnt;
        issue   = DIR_NONE;
        consume = 1'b0;
        if (frame_tick) begin
            case (state)
                S_IDLE: begin
                    if (pending_valid) begin
                        issue   = pending_dir;
                        held_d  = pending_dir;
                        cnt_d   = '0;
                        consume = 1'b1;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD, S_REPEAT: begin
                    if (pending_valid && pending_dir != held_dir) begin
                        issue   = pending_dir;
                        held_d  = pending_dir;
                        cnt_d   = '0;
                        consume = 1'b1;
                        state_d = S_HOLD;
                    end else if (dir == held_dir) begin
                        if (state == S_HOLD) begin
                            if (cnt == DELAY_LAST) begin
                                issue   = held_dir;
                                cnt_d   = '0;
                                state_d = S_REPEAT;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end else begin
                            if (cnt == PERIOD_LAST) begin
                                issue = held_dir;
                                cnt_d = '0;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Strobes are reloaded only on ticks, so each lasts exactly one frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mv_q         <= '0;
            move_count_q <= '0;
        end else if (frame_tick) begin
            mv_q <= dir_onehot(issue);
            if (issue != DIR_NONE) begin
                move_count_q <= move_count_q + 8'd1;
            end
        end
    end

    // Active-frog select and last-key capture.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frog_q     <= '0;
            last_key_q <= '0;
        end else begin
            case (kc_q)
                KC_FROG1: frog_q <= 3'b100;
                KC_FROG2: frog_q <= 3'b010;
                KC_FROG3: frog_q <= 3'b001;
                default:  frog_q <= frog_q;
            endcase
            if (kc_q != '0) begin
                last_key_q <= kc_q[LK_W-1:0];
            end
        end
    end

    assign {up, down, left, right}              = mv_q;
    assign {frog_1_key, frog_2_key, frog_3_key} = frog_q;
    assign last_key                             = last_key_q;
    assign move_count                           = move_count_q;

endmodule

// File: tb/tb_frog_input_ctrl.sv
// Self-checking bench for frog_input_ctrl: directed test-plan sequences, a
// keycode table, and random keycode stimulus against a frame-level reference model.
module tb_frog_input_ctrl;

    localparam int unsigned DELAY      = 8;
    localparam int unsigned PERIOD     = 4;
    localparam int unsigned HALF_FRAME = 20;
    localparam int unsigned FRAME      = 2 * HALF_FRAME;

    logic        Clk       = 1'b0;
    logic        Reset_n   = 1'b0;
    logic        frame_clk = 1'b0;
    logic [15:0] keycode   = 16'h0000;
    logic        up, down, left, right;
    logic        frog_1_key, frog_2_key, frog_3_key;
    logic [7:0]  last_key, move_count;

    int checks = 0;
    int errors = 0;

    frog_input_ctrl #(.REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .keycode    (keycode),
        .frame_clk  (frame_clk),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .frog_1_key (frog_1_key),
        .frog_2_key (frog_2_key),
        .frog_3_key (frog_3_key),
        .last_key   (last_key),
        .move_count (move_count)
    );

    initial forever #5 Clk = ~Clk;

    // Free-running vsync, FRAME Clk cycles per frame.
    initial begin
        forever begin
            repeat (HALF_FRAME) @(negedge Clk);
            frame_clk = ~frame_clk;
        end
    end

    // ---------------- reference model ----------------
    // Directions: 0 none, 1 up, 2 down, 3 left, 4 right.
    function automatic int kdir(input logic [15:0] k);
        case (k)
            16'h0052: return 1;
            16'h0051: return 2;
            16'h0050: return 3;
            16'h004F: return 4;
            default:  return 0;
        endcase
    endfunction

    function automatic logic [3:0] onehot(input int d);
        case (d)
            1: return 4'b1000;
            2: return 4'b0100;
            3: return 4'b0010;
            4: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    logic [15:0] m_kc1 = '0, m_kcq = '0;
    logic [2:0]  m_fs = '0;
    int          m_prev = 0, m_pend_d = 0, m_held = 0, m_frames = 0, m_out = 0;
    bit          m_pend_v = 0, m_rep = 0;
    logic [7:0]  m_cnt = '0, m_last = '0;
    logic [2:0]  m_frog = '0;
    int          m_ticks = 0;

    // The model thinks in frames: which key is held, how many frames since the
    // last move, and whether the initial delay has already elapsed.
    always @(posedge Clk or negedge Reset_n) begin
        int d, issue;
        bit tick, consumed;
        if (!Reset_n) begin
            m_kc1 = '0; m_kcq = '0; m_fs = '0;
            m_prev = 0; m_pend_d = 0; m_pend_v = 0;
            m_held = 0; m_frames = 0; m_rep = 0; m_out = 0;
            m_cnt = '0; m_last = '0; m_frog = '0;
        end else begin
            d        = kdir(m_kcq);
            tick     = m_fs[1] & ~m_fs[2];
            consumed = 0;
            issue    = 0;
            if (tick) begin
                m_ticks++;
                if (m_held == 0) begin
                    if (m_pend_v) begin issue = m_pend_d; consumed = 1; end
                end else if (m_pend_v && m_pend_d != m_held) begin
                    issue = m_pend_d; consumed = 1;
                end else if (d == m_held) begin
                    m_frames++;
                    if (m_frames == (m_rep ? int'(PERIOD) : int'(DELAY))) begin
                        issue = m_held; m_rep = 1; m_frames = 0;
                    end
                end else begin
                    m_held = 0;
                end
                if (consumed) begin m_held = issue; m_frames = 0; m_rep = 0; end
                m_out = issue;
                if (issue != 0) m_cnt = m_cnt + 8'd1;
            end
            if (d != 0 && d != m_prev) begin
                m_pend_v = 1; m_pend_d = d;
            end else if (consumed) begin
                m_pend_v = 0;
            end
            m_prev = d;
            case (m_kcq)
                16'h0059: m_frog = 3'b100;
                16'h005A: m_frog = 3'b010;
                16'h005B: m_frog = 3'b001;
                default:  m_frog = m_frog;
            endcase
            if (m_kcq != 16'h0000) m_last = m_kcq[7:0];
            m_fs  = {m_fs[1:0], frame_clk};
            m_kcq = m_kc1;
            m_kc1 = keycode;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns at the negedge following the next frame tick.
    task automatic wait_tick();
        int t0, n;
        t0 = m_ticks;
        n  = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (m_ticks == t0 && n < int'(3 * FRAME));
        if (m_ticks == t0) chk("tick_timeout", 32'(0), 32'(1));
    endtask

    function automatic logic [3:0] mv();
        return {up, down, left, right};
    endfunction

    typedef struct {
        logic [15:0] kc;
        logic [2:0]  frog;
        logic [7:0]  last;
    } vec_t;

    vec_t tbl[8];

    // ---------------- stimulus ----------------
    initial begin
        logic [19:0] got20;
        logic [7:0]  got8;
        int          n;
        logic [15:0] pool[10];

        tbl[0] = '{16'h0059, 3'b100, 8'h59};
        tbl[1] = '{16'h0000, 3'b100, 8'h59};
        tbl[2] = '{16'h005B, 3'b001, 8'h5B};
        tbl[3] = '{16'h1234, 3'b001, 8'h34};
        tbl[4] = '{16'h005A, 3'b010, 8'h5A};
        tbl[5] = '{16'h015A, 3'b010, 8'h5A};
        tbl[6] = '{16'h0050, 3'b010, 8'h50};
        tbl[7] = '{16'h0059, 3'b100, 8'h59};

        pool = '{16'h0000, 16'h0050, 16'h004F, 16'h0052, 16'h0051,
                 16'h0059, 16'h005A, 16'h005B, 16'h5052, 16'h0000};

        fork
            forever begin
                @(negedge Clk);
                chk("scoreboard",
                    32'({up, down, left, right, frog_1_key, frog_2_key, frog_3_key, last_key, move_count}),
                    32'({onehot(m_out), m_frog, m_last, m_cnt}));
            end
        join_none

        // Reset state
        repeat (3) @(negedge Clk);
        chk("reset_outputs",
            32'({up, down, left, right, frog_1_key, frog_2_key, frog_3_key, last_key, move_count}), 32'(0));
        Reset_n = 1'b1;

        // Unknown / multi-key code, then frog 2 select
        keycode = 16'h5052;
        wait_tick(); chk("multikey_no_move", 32'(mv()), 32'(0));
        wait_tick(); chk("multikey_no_move", 32'(mv()), 32'(0));
        chk("multikey_count", 32'(move_count), 32'(0));
        keycode = 16'h005A;
        repeat (2) @(negedge Clk);
        chk("frog2_before_latency", 32'(frog_2_key), 32'(0));
        @(negedge Clk);
        chk("frog2_latency", 32'(frog_2_key), 32'(1));
        keycode = 16'h0000;
        repeat (10) @(negedge Clk);
        chk("frog2_persist", 32'({frog_1_key, frog_2_key, frog_3_key}), 32'(3'b010));
        chk("last_key_5a", 32'(last_key), 32'(8'h5A));

        // Short tap mid-frame
        wait_tick();
        repeat (5) @(negedge Clk);
        keycode = 16'h0052;
        repeat (10) @(negedge Clk);
        keycode = 16'h0000;
        wait_tick();
        chk("tap_up", 32'(mv()), 32'(4'b1000));
        n = 0;
        for (int i = 0; i < int'(FRAME) + 10; i++) begin
            if (up) n++;
            @(negedge Clk);
        end
        chk("tap_width", 32'(n), 32'(FRAME));
        chk("tap_count", 32'(move_count), 32'(1));

        // Hold right for 20 frames
        wait_tick();
        keycode = 16'h004F;
        for (int t = 0; t < 20; t++) begin
            wait_tick();
            got20[t] = right;
        end
        chk("hold_repeat_pattern", 32'(got20), 32'(20'h11101));
        chk("hold_count", 32'(move_count), 32'(5));
        keycode = 16'h0000;
        wait_tick(); wait_tick();

        // Direction switch left -> down
        keycode = 16'h0050;
        wait_tick();
        chk("switch_left_first", 32'(mv()), 32'(4'b0010));
        wait_tick(); wait_tick();
        keycode = 16'h0051;
        wait_tick();
        chk("switch_down", 32'(mv()), 32'(4'b0100));
        for (int t = 0; t < 8; t++) begin
            wait_tick();
            got8[t] = down;
        end
        chk("switch_hold_restart", 32'(got8), 32'(8'b1000_0000));
        chk("switch_count", 32'(move_count), 32'(8));
        keycode = 16'h0000;
        wait_tick(); wait_tick();

        // Reset while in REPEAT, key still held afterwards
        keycode = 16'h0052;
        for (int t = 0; t < 9; t++) wait_tick();
        chk("repeat_up_before_reset", 32'(mv()), 32'(4'b1000));
        repeat (5) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("reset_async",
            32'({up, down, left, right, frog_1_key, frog_2_key, frog_3_key, last_key, move_count}), 32'(0));
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        n = 0;
        for (int t = 0; t < 4; t++) begin
            wait_tick();
            if (up) n++;
        end
        chk("reset_reissue_once", 32'(n), 32'(1));
        chk("reset_move_count", 32'(move_count), 32'(1));
        keycode = 16'h0000;
        wait_tick(); wait_tick();

        // Keycode table: frog select and last_key
        for (int i = 0; i < 8; i++) begin
            keycode = tbl[i].kc;
            repeat (4) @(negedge Clk);
            chk("table_frog", 32'({frog_1_key, frog_2_key, frog_3_key}), 32'(tbl[i].frog));
            chk("table_last_key", 32'(last_key), 32'(tbl[i].last));
        end
        keycode = 16'h0000;

        // Wrap: 256 moves from reset by alternating left/right every frame
        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        wait_tick(); wait_tick();
        keycode = 16'h0050;
        for (int i = 0; i < 256; i++) begin
            wait_tick();
            keycode = (i % 2 == 0) ? 16'h004F : 16'h0050;
            if (i == 254) chk("wrap_255", 32'(move_count), 32'(255));
        end
        chk("wrap_zero", 32'(move_count), 32'(0));
        keycode = 16'h0000;

        // Random keycodes against the model
        for (int i = 0; i < 60; i++) begin
            if (($urandom % 8) == 0) keycode = 16'($urandom);
            else keycode = pool[$urandom_range(0, 9)];
            repeat ($urandom_range(1, 90)) @(negedge Clk);
        end
        keycode = 16'h0000;
        repeat (3 * FRAME) @(negedge Clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
